// File: rtl/countdown_timer_if.sv
`timescale 1ns/1ps
// Button/tick inputs and display/alarm outputs of the countdown timer.
// Latency: none (wires only).
// Backpressure: none; inputs are levels or one-cycle enables.
//
// Ports (slave = timer side):
//   tick, set_en, btn_start, btn_min, btn_sec, btn_clr : into the timer
//   sec0, sec1, min_bcd, running, expired, buzzer      : out of the timer
interface countdown_timer_if #(
    parameter int MIN_DIGITS = 2
);
    logic                    tick;
    logic                    set_en;
    logic                    btn_start;
    logic                    btn_min;
    logic                    btn_sec;
    logic                    btn_clr;
    logic [3:0]              sec0;
    logic [3:0]              sec1;
    logic [4*MIN_DIGITS-1:0] min_bcd;
    logic                    running;
    logic                    expired;
    logic                    buzzer;

    modport master (
        output tick, set_en, btn_start, btn_min, btn_sec, btn_clr,
        input  sec0, sec1, min_bcd, running, expired, buzzer
    );

    modport slave (
        input  tick, set_en, btn_start, btn_min, btn_sec, btn_clr,
        output sec0, sec1, min_bcd, running, expired, buzzer
    );
endinterface

// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
// BCD MM..M:SS countdown timer with button setting, start/pause, expiry buzzer.
// Latency: tick -> digits 1 cycle; button pin -> effect 3 cycles (2 sync + edge).
// Backpressure: none; every tick and every button edge is acted on in its cycle.
//
// Ports: uclock (clock), reset (sync, active-high), tif (countdown_timer_if.slave):
//   tick/set_en/btn_* in; sec0, sec1, min_bcd, running, expired, buzzer out (all registered).
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (reload on expiry and keep running).
module countdown_timer #(
    parameter int MIN_DIGITS = 2,
    parameter int PRESET_MIN = 3,
    parameter int BUZZ_TICKS = 10
) (
    input  logic             uclock,
    input  logic             reset,
    countdown_timer_if.slave tif
);
    localparam int MW = 4 * MIN_DIGITS;
    localparam logic [7:0] BUZZ_LIM = 8'(BUZZ_TICKS);

    typedef struct packed {
        logic [MW-1:0] mins;
        logic [3:0]    s1;
        logic [3:0]    s0;
    } val_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    // Constant conversion of the reset minutes into per-digit BCD.
    function automatic logic [MW-1:0] preset_bcd();
        logic [MW-1:0] r;
        int p;
        r = '0;
        p = PRESET_MIN;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    localparam logic [MW-1:0] PRESET_MINS = preset_bcd();

    // Ripple BCD +1 over the minute digits; all-nines wraps to zero.
    function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic carry;
        r = m;
        carry = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (carry) begin
                if (m[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = m[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple BCD -1 over the minute digits; only called with minutes != 0.
    function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic borrow;
        r = m;
        borrow = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (m[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = m[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Seconds +1 with 59 -> 00 and no carry into minutes.
    function automatic val_t sec_inc(input val_t v);
        val_t r;
        r = v;
        if (v.s0 == 4'd9) begin
            r.s0 = 4'd0;
            r.s1 = (v.s1 == 4'd5) ? 4'd0 : v.s1 + 4'd1;
        end else begin
            r.s0 = v.s0 + 4'd1;
        end
        return r;
    endfunction

    // One-second countdown step with borrow; caller guarantees value != 0.
    function automatic val_t val_dec(input val_t v);
        val_t r;
        r = v;
        if (v.s0 != 4'd0) begin
            r.s0 = v.s0 - 4'd1;
        end else begin
            r.s0 = 4'd9;
            if (v.s1 != 4'd0) begin
                r.s1 = v.s1 - 4'd1;
            end else begin
                r.s1   = 4'd5;
                r.mins = min_dec(v.mins);
            end
        end
        return r;
    endfunction

    // Button synchronisers and edge history, bit order {clr, start, min, sec}.
    logic [3:0] btn_s1, btn_s2, btn_prev;
    logic [3:0] btn_rise;
    logic       e_clr, e_start, e_min, e_sec, any_edge;

    state_t     state_q, state_n;
    val_t       val_q, val_n, reload_q, reload_n;
    logic [7:0] buzz_cnt_q, buzz_cnt_n;
    logic       running_q, running_n;
    logic       expired_q, expired_n;
    logic       buzzer_q, buzzer_n;
    logic       is_one;

    assign btn_rise = btn_s2 & ~btn_prev & {4{tif.set_en}};
    assign e_clr    = btn_rise[3];
    assign e_start  = btn_rise[2];
    assign e_min    = btn_rise[1];
    assign e_sec    = btn_rise[0];
    assign any_edge = |btn_rise;

    // The next tick would land on 00:00.
    assign is_one = (val_q.mins == '0) && (val_q.s1 == 4'd0) && (val_q.s0 == 4'd1);

    always_ff @(posedge uclock) begin
        if (reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_prev   <= '0;
            state_q    <= IDLE;
            val_q      <= '{mins: PRESET_MINS, s1: 4'd0, s0: 4'd0};
            reload_q   <= '{mins: PRESET_MINS, s1: 4'd0, s0: 4'd0};
            buzz_cnt_q <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            btn_s1     <= {tif.btn_clr, tif.btn_start, tif.btn_min, tif.btn_sec};
            btn_s2     <= btn_s1;
            btn_prev   <= btn_s2;
            state_q    <= state_n;
            val_q      <= val_n;
            reload_q   <= reload_n;
            buzz_cnt_q <= buzz_cnt_n;
            running_q  <= running_n;
            expired_q  <= expired_n;
            buzzer_q   <= buzzer_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        val_n      = val_q;
        reload_n   = reload_q;
        buzz_cnt_n = buzz_cnt_q;
        buzzer_n   = buzzer_q;
        expired_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (e_clr) begin
                    val_n = '0;
                end else if (e_start) begin
                    if (val_q != '0) begin
                        reload_n = val_q;
                        state_n  = RUN;
                    end
                end else if (e_min) begin
                    val_n.mins = min_inc(val_q.mins);
                end else if (e_sec) begin
                    val_n = sec_inc(val_q);
                end
            end

            RUN: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (buzzer_q && any_edge) begin
                    // A press while the alarm sounds only silences it.
                    buzzer_n = 1'b0;
                end else begin
                    if (buzzer_q && tick_in()) begin
                        buzz_cnt_n = buzz_cnt_q + 8'd1;
                        if (buzz_cnt_q + 8'd1 == BUZZ_LIM) begin
                            buzzer_n = 1'b0;
                        end
                    end
                    if (e_clr) begin
                        state_n = IDLE;
                        val_n   = reload_q;
                    end else if (e_start) begin
                        state_n = PAUSE;
                    end
                end
                if (tif.tick && (state_n != IDLE)) begin
                    if (is_one) begin
                        val_n      = reload_q;
                        expired_n  = 1'b1;
                        buzzer_n   = 1'b1;
                        buzz_cnt_n = '0;
                    end else begin
                        val_n = val_dec(val_q);
                    end
                end
`else
                if (e_clr) begin
                    state_n = IDLE;
                    val_n   = reload_q;
                end else begin
                    if (e_start) begin
                        state_n = PAUSE;
                    end
                    // Expiry wins over a simultaneous pause.
                    if (tif.tick) begin
                        if (is_one) begin
                            val_n      = '0;
                            state_n    = EXPIRED;
                            buzzer_n   = 1'b1;
                            buzz_cnt_n = '0;
                        end else begin
                            val_n = val_dec(val_q);
                        end
                    end
                end
`endif
            end

            PAUSE: begin
                if (e_clr) begin
                    state_n = IDLE;
                    val_n   = reload_q;
                end else if (e_start) begin
                    state_n = RUN;
                end
            end

            EXPIRED: begin
                if (any_edge) begin
                    state_n  = IDLE;
                    val_n    = reload_q;
                    buzzer_n = 1'b0;
                end else if (tif.tick) begin
                    buzz_cnt_n = buzz_cnt_q + 8'd1;
                    if (buzz_cnt_q + 8'd1 == BUZZ_LIM) begin
                        state_n  = IDLE;
                        val_n    = reload_q;
                        buzzer_n = 1'b0;
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                buzzer_n = 1'b0;
            end
        endcase

`ifndef COUNTDOWN_AUTORELOAD_EN
        expired_n = (state_n == EXPIRED);
`endif
        running_n = (state_n == RUN);
    end

`ifdef COUNTDOWN_AUTORELOAD_EN
    function automatic logic tick_in();
        return tif.tick;
    endfunction
`endif

    assign tif.sec0    = val_q.s0;
    assign tif.sec1    = val_q.s1;
    assign tif.min_bcd = val_q.mins;
    assign tif.running = running_q;
    assign tif.expired = expired_q;
    assign tif.buzzer  = buzzer_q;
endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
// Directed bench for countdown_timer (MIN_DIGITS=2, PRESET_MIN=3, BUZZ_TICKS=10).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_countdown_timer;
    logic uclock = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] disp;

    countdown_timer_if #(.MIN_DIGITS(2)) tif ();

    countdown_timer #(
        .MIN_DIGITS(2),
        .PRESET_MIN(3),
        .BUZZ_TICKS(10)
    ) dut (
        .uclock(uclock),
        .reset (reset),
        .tif   (tif)
    );

    always #5 uclock = ~uclock;

    assign disp = {tif.min_bcd, tif.sec1, tif.sec0};

    task automatic cyc(input int n);
        repeat (n) @(negedge uclock);
    endtask

    // b = {clr, start, min, sec}; held long enough to pass sync + edge, then released.
    task automatic press(input logic [3:0] b);
        {tif.btn_clr, tif.btn_start, tif.btn_min, tif.btn_sec} = b;
        cyc(3);
        {tif.btn_clr, tif.btn_start, tif.btn_min, tif.btn_sec} = 4'b0000;
        cyc(3);
    endtask

    task automatic press_n(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tif.tick = 1'b1;
            cyc(1);
            tif.tick = 1'b0;
            cyc(1);
        end
    endtask

    localparam logic [3:0] B_CLR = 4'b1000, B_START = 4'b0100, B_MIN = 4'b0010, B_SEC = 4'b0001;

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        checks++; if (tif.min_bcd !== 8'h03) begin errors++; $display("FAIL reset_min got=%h exp=03", tif.min_bcd); end
        checks++; if (tif.sec0 !== 4'h0) begin errors++; $display("FAIL reset_sec0 got=%h exp=0", tif.sec0); end
        checks++; if (tif.sec1 !== 4'h0) begin errors++; $display("FAIL reset_sec1 got=%h exp=0", tif.sec1); end
        checks++; if (tif.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", tif.running); end
        checks++; if (tif.expired !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b exp=0", tif.expired); end
        checks++; if (tif.buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b exp=0", tif.buzzer); end
    endtask

    task automatic test_set_and_expire();
        press(B_CLR);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clr_value got=%h exp=0000", disp); end
        press(B_MIN);
        press_n(B_SEC, 5);
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL set_0105 got=%h exp=0105", disp); end
        press(B_START);
        checks++; if (tif.running !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", tif.running); end
        ticks(5);
        checks++; if (disp !== 16'h0100) begin errors++; $display("FAIL run_0100 got=%h exp=0100", disp); end
        ticks(1);
        checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL borrow_0059 got=%h exp=0059", disp); end
        ticks(58);
        checks++; if (disp !== 16'h0001 || tif.expired !== 1'b0) begin errors++; $display("FAIL pre_expiry got=%h/%b exp=0001/0", disp, tif.expired); end
        ticks(1);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL expiry_value got=%h exp=0000", disp); end
        checks++; if (tif.expired !== 1'b1) begin errors++; $display("FAIL expiry_expired got=%b exp=1", tif.expired); end
        checks++; if (tif.buzzer !== 1'b1) begin errors++; $display("FAIL expiry_buzzer got=%b exp=1", tif.buzzer); end
        checks++; if (tif.running !== 1'b0) begin errors++; $display("FAIL expiry_running got=%b exp=0", tif.running); end
        ticks(9);
        checks++; if (tif.buzzer !== 1'b1) begin errors++; $display("FAIL buzz_9_ticks got=%b exp=1", tif.buzzer); end
        ticks(1);
        checks++; if (tif.buzzer !== 1'b0 || tif.expired !== 1'b0) begin errors++; $display("FAIL buzz_end got=%b/%b exp=0/0", tif.buzzer, tif.expired); end
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL reload_0105 got=%h exp=0105", disp); end
    endtask

    task automatic test_buzzer_abort();
        press(B_CLR);
        press(B_SEC);
        press(B_START);
        ticks(1);
        checks++; if (tif.buzzer !== 1'b1) begin errors++; $display("FAIL abort_pre_buzzer got=%b exp=1", tif.buzzer); end
        press(B_MIN);
        checks++; if (tif.buzzer !== 1'b0 || tif.expired !== 1'b0) begin errors++; $display("FAIL abort_flags got=%b/%b exp=0/0", tif.buzzer, tif.expired); end
        checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL abort_value got=%h exp=0001", disp); end
    endtask

    task automatic test_zero_start_and_wraps();
        press(B_CLR);
        press(B_START);
        checks++; if (tif.running !== 1'b0 || disp !== 16'h0000) begin errors++; $display("FAIL zero_start got=%b/%h exp=0/0000", tif.running, disp); end
        press(B_MIN);
        press_n(B_SEC, 59);
        checks++; if (disp !== 16'h0159) begin errors++; $display("FAIL sec_59 got=%h exp=0159", disp); end
        press(B_SEC);
        checks++; if (disp !== 16'h0100) begin errors++; $display("FAIL sec_wrap got=%h exp=0100", disp); end
        press(B_CLR);
        press_n(B_MIN, 99);
        checks++; if (disp !== 16'h9900) begin errors++; $display("FAIL min_99 got=%h exp=9900", disp); end
        press(B_MIN);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL min_wrap got=%h exp=0000", disp); end
    endtask

    task automatic test_priority_and_set_en();
        press(B_MIN);
        press(B_MIN | B_SEC);
        checks++; if (disp !== 16'h0200) begin errors++; $display("FAIL prio_min_sec got=%h exp=0200", disp); end
        press(B_CLR | B_MIN);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL prio_clr got=%h exp=0000", disp); end
        tif.set_en = 1'b0;
        press(B_MIN);
        tif.set_en = 1'b1;
        cyc(1);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL set_en_off got=%h exp=0000", disp); end
    endtask

    task automatic test_tick_start_same_cycle();
        press(B_CLR);
        press_n(B_SEC, 10);
        press(B_START);
        checks++; if (tif.running !== 1'b1 || disp !== 16'h0010) begin errors++; $display("FAIL run_0010 got=%b/%h exp=1/0010", tif.running, disp); end
        tif.btn_start = 1'b1;
        cyc(2);
        tif.tick = 1'b1;
        cyc(1);
        tif.tick = 1'b0;
        checks++; if (disp !== 16'h0009 || tif.running !== 1'b0) begin errors++; $display("FAIL tick_start got=%h/%b exp=0009/0", disp, tif.running); end
        tif.btn_start = 1'b0;
        cyc(3);
        ticks(5);
        checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL pause_hold got=%h exp=0009", disp); end
        press(B_START);
        ticks(1);
        checks++; if (disp !== 16'h0008 || tif.running !== 1'b1) begin errors++; $display("FAIL resume got=%h/%b exp=0008/1", disp, tif.running); end
        press(B_START);
        press(B_CLR);
        checks++; if (disp !== 16'h0010 || tif.running !== 1'b0) begin errors++; $display("FAIL pause_clr got=%h/%b exp=0010/0", disp, tif.running); end
    endtask

    task automatic test_reset_mid_run();
        press(B_CLR);
        press_n(B_SEC, 42);
        press(B_START);
        checks++; if (disp !== 16'h0042 || tif.running !== 1'b1) begin errors++; $display("FAIL run_0042 got=%h/%b exp=0042/1", disp, tif.running); end
        reset = 1'b1;
        tif.tick = 1'b1;
        cyc(1);
        checks++; if (disp !== 16'h0300 || tif.running !== 1'b0 || tif.buzzer !== 1'b0) begin errors++; $display("FAIL reset_mid got=%h/%b/%b exp=0300/0/0", disp, tif.running, tif.buzzer); end
        reset = 1'b0;
        tif.tick = 1'b0;
        cyc(2);
    endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
    task automatic test_autoreload();
        press(B_CLR);
        press_n(B_SEC, 2);
        press(B_START);
        ticks(1);
        tif.tick = 1'b1;
        cyc(1);
        tif.tick = 1'b0;
        checks++; if (disp !== 16'h0002 || tif.expired !== 1'b1 || tif.running !== 1'b1 || tif.buzzer !== 1'b1) begin errors++; $display("FAIL ar_expiry got=%h/%b/%b/%b exp=0002/1/1/1", disp, tif.expired, tif.running, tif.buzzer); end
        cyc(1);
        checks++; if (tif.expired !== 1'b0 || tif.buzzer !== 1'b1) begin errors++; $display("FAIL ar_pulse got=%b/%b exp=0/1", tif.expired, tif.buzzer); end
        press(B_MIN);
        checks++; if (tif.buzzer !== 1'b0 || tif.running !== 1'b1 || disp !== 16'h0002) begin errors++; $display("FAIL ar_silence got=%b/%b/%h exp=0/1/0002", tif.buzzer, tif.running, disp); end
        press(B_CLR);
        press(B_CLR);
        press_n(B_SEC, 15);
        press(B_START);
        ticks(15);
        checks++; if (disp !== 16'h0015 || tif.buzzer !== 1'b1) begin errors++; $display("FAIL ar_15 got=%h/%b exp=0015/1", disp, tif.buzzer); end
        ticks(9);
        checks++; if (disp !== 16'h0006 || tif.buzzer !== 1'b1) begin errors++; $display("FAIL ar_buzz9 got=%h/%b exp=0006/1", disp, tif.buzzer); end
        ticks(1);
        checks++; if (disp !== 16'h0005 || tif.buzzer !== 1'b0) begin errors++; $display("FAIL ar_buzz10 got=%h/%b exp=0005/0", disp, tif.buzzer); end
    endtask
`endif

    initial begin
        tif.tick      = 1'b0;
        tif.set_en    = 1'b1;
        tif.btn_start = 1'b0;
        tif.btn_min   = 1'b0;
        tif.btn_sec   = 1'b0;
        tif.btn_clr   = 1'b0;
        test_reset();
`ifndef COUNTDOWN_AUTORELOAD_EN
        test_set_and_expire();
        test_buzzer_abort();
`endif
        test_zero_start_and_wraps();
        test_priority_and_set_en();
        test_tick_start_same_cycle();
        test_reset_mid_run();
`ifdef COUNTDOWN_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised BCD countdown timer for the FPWW watch face: MM..M:SS display digits, button-driven setting, start/pause, expiry buzzer with bounded duration and optional auto-reload. It sits beside the clock and stopwatch modes, is clocked by the fast system clock, and advances only on a one-cycle `tick` enable from the shared seconds prescaler. Digit outputs feed the existing 7-segment multiplexer unchanged.

## Interface
Parameters:
- `MIN_DIGITS`, default 2: number of BCD minute digits (1..4); minutes range 0..10^MIN_DIGITS-1.
- `PRESET_MIN`, default 3: minutes loaded at reset; must be < 10^MIN_DIGITS.
- `BUZZ_TICKS`, default 10: ticks the buzzer stays on after expiry (1..255).

Ports (one clock; reset is synchronous and active-high):
- `uclock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: one-`uclock`-cycle pulse, once per second.
- `set_en` in 1: level; timer mode selected (both mode switches on).
- `btn_start` in 1: level; start/pause toggle.
- `btn_min` in 1: level; increment minutes.
- `btn_sec` in 1: level; increment seconds.
- `btn_clr` in 1: level; clear / abort.
- `sec0`, `sec1` out 4 each: seconds ones (0..9), tens (0..5), BCD.
- `min_bcd` out 4*MIN_DIGITS: minute digits, digit 0 in bits [3:0].
- `running` out 1: high in RUN.
- `expired` out 1: high in EXPIRED (level), or one-cycle pulse with auto-reload.
- `buzzer` out 1: alarm drive.

## Operation
- Buttons: synchronised (2 flops) then rising-edge detected internally; each press acts exactly once, one cycle. Buttons ignored when `set_en`=0.
- States: IDLE, RUN, PAUSE, EXPIRED. Internal `reload` register holds the last started value.
- IDLE: `btn_sec` +1 second, 59->00 with no carry into minutes; `btn_min` +1 minute, max->0; `btn_clr` sets 00:00; `btn_start` with value != 0 copies value to `reload` and enters RUN; with value 0 it is ignored. Priority if several edges in one cycle: clr > start > min > sec.
- RUN: each `tick` decrements one second with BCD borrow (x0 -> (x-1)9, :00 -> (m-1):59). Tick producing 00:00 enters EXPIRED. `btn_start` -> PAUSE; `btn_clr` -> IDLE with value = `reload`. Tick and start in same cycle: decrement applies, then PAUSE.
- PAUSE: ticks ignored; `btn_start` -> RUN; `btn_clr` -> IDLE, value = `reload`.
- EXPIRED: digits 00:00, `buzzer`=1; counter counts `tick`s, after BUZZ_TICKS ticks or any button edge -> IDLE with value = `reload`, `buzzer`=0.
- Arithmetic purely BCD per digit; no binary intermediate; no digit ever leaves its legal range.

## Timing
- Reset values: minutes = PRESET_MIN (BCD), seconds 00, `reload` = same, state IDLE, `running`=0, `expired`=0, `buzzer`=0, button history cleared.
- All outputs registered. Digit update visible the cycle after the `tick` (or button edge) is sampled.
- Button latency: 3 `uclock` cycles from pin rise to state/digit change (2 sync + edge).
- `expired` and `buzzer` rise in the same cycle the digits show 00:00.
- The expiring tick does not count toward BUZZ_TICKS; buzzer falls the cycle after the BUZZ_TICKS-th later tick is sampled.
- Reset mid-operation overrides everything in that cycle; no pending edge survives reset.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined: the tick that would reach 00:00 instead loads `reload` and stays in RUN; `expired` is a one-cycle pulse; `buzzer` still runs BUZZ_TICKS ticks (restarting if it expires again) while counting continues; any button edge silences it without leaving RUN.
- Not defined: EXPIRED state behaviour above; timer stops at 00:00.

## Test plan
- Reset with defaults -> `min_bcd`=8'h03, sec 00, IDLE, all flags 0.
- Set 01:05 via presses, start, 65 ticks -> digits step 01:00 -> 00:59 correctly, `expired`=`buzzer`=1 on 65th tick; 10 more ticks -> IDLE, display 01:05.
- Start at 00:00 -> ignored, `running`=0; `btn_sec` 60 presses from 00 -> wraps to 00, minutes unchanged.
- RUN 00:10, tick and `btn_start` edge same cycle -> 00:09 and PAUSE; 5 ticks -> still 00:09; `btn_clr` -> IDLE 00:10.
- `reset` asserted mid-RUN at 00:42 -> next cycle 03:00 IDLE, `buzzer`=0.
- With `COUNTDOWN_AUTORELOAD_EN`, start 00:02, 2 ticks -> display 00:02, one-cycle `expired`, `running`=1, `buzzer` high 10 ticks unless a button edge clears it.
